dmem_access_arbiter: RTL and testbench

Arbitrates two 64-bit doubleword requesters (port 0 = pipeline MEM stage, port 1 = loader/debug) onto a single byte-wide data RAM. Each granted access is serialised into 8 little-endian byte beats. A 64-bit result is returned with a one-cycle ack. A stall is driven to the pipeline while port 0 waits. The block sits between the MEM stage and the byte-array data memory.

---
 rtl/dmem_access_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_access_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_arbiter.sv
// Two-port doubleword arbiter onto a byte-wide data RAM. Each granted access
// is serialised into 8 little-endian byte beats and completes with a one-cycle ack.
module dmem_access_arbiter #(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [63:0]       addr_0,
    input  logic [63:0]       wdata_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [63:0]       addr_1,
    input  logic [63:0]       wdata_1,
    output logic              ack_0,
    output logic              ack_1,
    output logic [63:0]       rdata,
    output logic              err,
    output logic              stall_0,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_reg;
    logic [2:0]        beat_reg;
    logic              grant_reg;
    logic              last_grant_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [63:0]       wdata_reg;
    logic [63:0]       rdata_reg;
    logic              err_reg;

    logic              in_xfer;
    logic              in_done;
    logic              grant_valid;
    logic              grant_sel;
    logic              sel_we;
    logic [63:0]       sel_addr;
    logic [63:0]       sel_wdata;
    logic              sel_fault;
    logic [7:0]        lane_hit;
    logic [7:0]        wbyte [8];
    logic [63:0]       rdata_next;

    assign in_xfer = (state_reg == ST_XFER);
    assign in_done = (state_reg == ST_DONE);

    // Round robin: on a tie the port that was not granted last time wins.
    always_comb begin
        grant_valid = req_0 | req_1;
        grant_sel   = 1'b0;
        if (req_0 && req_1) begin
            grant_sel = ~last_grant_reg;
        end else if (req_1) begin
            grant_sel = 1'b1;
        end
    end

    always_comb begin
        sel_we    = we_0;
        sel_addr  = addr_0;
        sel_wdata = wdata_0;
        if (grant_sel) begin
            sel_we    = we_1;
            sel_addr  = addr_1;
            sel_wdata = wdata_1;
        end
    end

    assign sel_fault = (sel_addr[2:0] != 3'd0) || (sel_addr >= 64'(MEM_BYTES));

    // Per-byte lanes: write byte selection and read byte capture by beat index.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_hit[gi] = (beat_reg == 3'(gi));
            assign wbyte[gi]    = wdata_reg[8*gi +: 8];
            assign rdata_next[8*gi +: 8] = (!we_reg && lane_hit[gi]) ? mem_rdata
                                                                     : rdata_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            beat_reg       <= 3'd0;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= 64'd0;
            rdata_reg      <= 64'd0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        grant_reg      <= grant_sel;
                        last_grant_reg <= grant_sel;
                        we_reg         <= sel_we;
                        addr_reg       <= sel_addr[ADDR_W-1:0];
                        wdata_reg      <= sel_wdata;
                        rdata_reg      <= 64'd0;
                        err_reg        <= sel_fault;
                        beat_reg       <= 3'd0;
                        state_reg      <= sel_fault ? ST_DONE : ST_XFER;
                    end
                end
                ST_XFER: begin
                    rdata_reg <= rdata_next;
                    beat_reg  <= beat_reg + 3'd1;
                    if (beat_reg == 3'd7) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state so an async reset clears them at once.
    assign ack_0     = in_done & ~grant_reg;
    assign ack_1     = in_done & grant_reg;
    assign rdata     = in_done ? rdata_reg : 64'd0;
    assign err       = in_done & err_reg;
    assign stall_0   = req_0 & ~ack_0;
    assign busy      = in_xfer | in_done;
    assign mem_addr  = in_xfer ? (addr_reg + ADDR_W'(beat_reg)) : '0;
    assign mem_we    = in_xfer & we_reg;
    assign mem_wdata = (in_xfer && we_reg) ? wbyte[beat_reg] : 8'd0;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Randomised bench for dmem_access_arbiter: byte RAM, shadow-memory reference
// model and round-robin/latency expectations derived from the access rules.
module tb_dmem_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_0, we_0, req_1, we_1;
    logic [63:0] addr_0, wdata_0, addr_1, wdata_1;
    logic        ack_0, ack_1, err, stall_0, busy, mem_we;
    logic [63:0] rdata;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  ram [64] = '{8: 8'h05, default: 8'h00};
    logic [7:0]  shadow [64];
    int          last_port;
    int          n_cmp = 0;
    int          n_bad = 0;

    dmem_access_arbiter #(.MEM_BYTES(64), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .ack_0(ack_0), .ack_1(ack_1), .rdata(rdata), .err(err),
        .stall_0(stall_0), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic is_fault(input logic [63:0] a);
        return (a[2:0] != 3'd0) || (a >= 64'd64);
    endfunction

    // Reference: a doubleword access on a flat byte array.
    task automatic model_apply(input logic w, input logic [63:0] a, input logic [63:0] d,
                               output logic [63:0] er, output logic ee);
        er = 64'd0;
        ee = is_fault(a);
        if (!ee) begin
            for (int i = 0; i < 8; i++) begin
                if (w) shadow[a[5:0] + 6'(i)] = d[8*i +: 8];
                else   er[8*i +: 8] = shadow[a[5:0] + 6'(i)];
            end
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [63:0] a, input logic [63:0] d);
        if (p == 0) begin req_0 = r; we_0 = w; addr_0 = a; wdata_0 = d; end
        else        begin req_1 = r; we_1 = w; addr_1 = a; wdata_1 = d; end
    endtask

    task automatic ram_compare();
        logic [63:0] g, e;
        for (int dw = 0; dw < 8; dw++) begin
            for (int i = 0; i < 8; i++) begin
                g[8*i +: 8] = ram[8*dw + i];
                e[8*i +: 8] = shadow[8*dw + i];
            end
            check($sformatf("ram_dw%0d", dw), g, e);
        end
    endtask

    task automatic do_txn(input int p, input logic w, input logic [63:0] a, input logic [63:0] d);
        logic [63:0] er;
        logic        ee, ackp;
        int          lat, got;
        model_apply(w, a, d, er, ee);
        lat = ee ? 1 : 9;
        drive(p, 1'b1, w, a, d);
        #1;
        check("stall0_req", stall_0, p == 0);
        got = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            ackp = (p == 0) ? ack_0 : ack_1;
            if (ackp) begin got = c; break; end
            check("busy", busy, 1'b1);
            check("stall0_wait", stall_0, p == 0);
            check("mem_we", mem_we, w && !ee);
            if (!ee) begin
                check("mem_addr", mem_addr, a[5:0] + 6'(c - 1));
                if (w) check("mem_wdata", mem_wdata, d[8*(c-1) +: 8]);
            end
        end
        check("latency", got, lat);
        check("rdata", rdata, er);
        check("err", err, ee);
        check("other_ack", (p == 0) ? ack_1 : ack_0, 1'b0);
        check("stall0_ack", stall_0, 1'b0);
        $display("txn port=%0d we=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 p, w, a, d, rdata, err, got);
        drive(p, 1'b0, 1'b0, 64'd0, 64'd0);
        last_port = p;
        @(posedge clk); #1;
        check("idle_busy", busy, 1'b0);
    endtask

    task automatic do_pair(input logic w0, input logic [63:0] a0, input logic [63:0] d0,
                           input logic w1, input logic [63:0] a1, input logic [63:0] d1);
        logic [63:0] er [2];
        logic        ee [2];
        int          first, lat_f, lat_s, got0, got1, exp0, exp1;
        first = 1 - last_port;
        if (first == 0) begin
            model_apply(w0, a0, d0, er[0], ee[0]);
            model_apply(w1, a1, d1, er[1], ee[1]);
        end else begin
            model_apply(w1, a1, d1, er[1], ee[1]);
            model_apply(w0, a0, d0, er[0], ee[0]);
        end
        lat_f = ee[first] ? 1 : 9;
        lat_s = ee[1-first] ? 1 : 9;
        exp0 = (first == 0) ? lat_f : lat_f + 1 + lat_s;
        exp1 = (first == 1) ? lat_f : lat_f + 1 + lat_s;
        drive(0, 1'b1, w0, a0, d0);
        drive(1, 1'b1, w1, a1, d1);
        got0 = -1;
        got1 = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            check("ack_overlap", ack_0 & ack_1, 1'b0);
            if (ack_0) begin
                got0 = c;
                check("pair_rdata0", rdata, er[0]);
                check("pair_err0", err, ee[0]);
                drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
            end
            if (ack_1) begin
                got1 = c;
                check("pair_rdata1", rdata, er[1]);
                check("pair_err1", err, ee[1]);
                drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
            end
            if (got0 >= 0 && got1 >= 0) break;
        end
        check("pair_lat0", got0, exp0);
        check("pair_lat1", got1, exp1);
        $display("pair first=%0d a0=%h a1=%h ack0_cycle=%0d ack1_cycle=%0d", first, a0, a1, got0, got1);
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        last_port = 1 - first;
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 64'(8 * $urandom_range(0, 7) + $urandom_range(1, 7));
        if (r == 1) return 64'(64 + 8 * $urandom_range(0, 100));
        return 64'(8 * $urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
        shadow[8] = 8'h05;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", ack_0, 1'b0);
        check("rst_ack1", ack_1, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 6'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_err", err, 1'b0);
        reset = 1'b0;
        last_port = 1;

        // Simultaneous requests straight after reset, twice.
        do_pair(1'b0, 64'd8, 64'd0, 1'b0, 64'd0, 64'd0);
        do_pair(1'b0, 64'd24, 64'd0, 1'b0, 64'd8, 64'd0);

        do_txn(0, 1'b0, 64'd8, 64'd0);
        do_txn(1, 1'b1, 64'd16, 64'h0807060504030201);
        do_txn(0, 1'b0, 64'd16, 64'd0);
        do_txn(0, 1'b0, 64'd3, 64'd0);
        do_txn(1, 1'b1, 64'd64, 64'hDEAD_BEEF_0123_4567);
        ram_compare();

        // Reset during beat 4 of a store: first four bytes stay written.
        drive(0, 1'b1, 1'b1, 64'd32, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (5) begin @(posedge clk); #1; end
        check("abort_addr", mem_addr, 6'd36);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_mem_we", mem_we, 1'b0);
        check("abort_mem_addr", mem_addr, 6'd0);
        check("abort_ack", {ack_0, ack_1}, 2'b00);
        check("abort_rdata", rdata, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 32; i < 36; i++) shadow[i] = 8'hFF;
        last_port = 1;
        ram_compare();
        do_pair(1'b0, 64'd32, 64'd0, 1'b1, 64'd40, 64'h1122_3344_5566_7788);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_pair(1'($urandom_range(0, 1)), rand_addr(), {$urandom(), $urandom()},
                        1'($urandom_range(0, 1)), rand_addr(), {$urandom(), $urandom()});
            end else begin
                do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
                       {$urandom(), $urandom()});
            end
            if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        end
        ram_compare();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
